// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared state encoding, PC-select codes and reset vector for
//               the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t FETCH = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t HALT  = 2'd2;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_JAL = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_calc
// Description : Combinational next-PC selection and jr alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  pc_control,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;
    logic        w_unused_opcode;

    assign w_pc_plus4  = pc + 32'd4;
    assign w_br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Opcode field is decoded by the controller, not here.
    assign w_unused_opcode = &{1'b0, instr[31:26]};

    always_comb begin
        next_pc = w_pc_plus4;
        case (pc_control)
            PC_BR:   next_pc = w_pc_plus4 + w_br_offset;
            PC_JR:   next_pc = rs_data;
            PC_JAL:  next_pc = {w_pc_plus4[31:28], instr[25:0], 2'b00};
            default: next_pc = w_pc_plus4;
        endcase
    end

    assign misaligned = (pc_control == PC_JR) && (rs_data[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC register, fetch/issue sequencer and misaligned-jr halt.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  pc_control,
    input  logic [31:0] rs_data,
    input  logic        issue_ack,
    output logic        fault
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_fault;
    logic [31:0] w_next_pc;
    logic        w_misaligned;

    next_pc_calc u_next_pc_calc (
        .pc         (r_pc),
        .instr      (r_instr),
        .pc_control (pc_control),
        .rs_data    (rs_data),
        .next_pc    (w_next_pc),
        .misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A misaligned jr keeps the faulting pc for inspection.
                    if (issue_ack) begin
                        if (w_misaligned) begin
                            r_fault <= 1'b1;
                            r_state <= HALT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= FETCH;
                        end
                    end
                end
                HALT:    r_state <= HALT;
                default: r_state <= HALT;
            endcase
        end
    end

    assign imem_req    = (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == ISSUE);
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign fault       = r_fault;

endmodule
`default_nettype wire
